fminmax_seq: RTL



---
 rtl/fp_pkg.sv | 27 ++
 rtl/fp32_lt.sv | 27 ++
 rtl/fminmax_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared fp32 definitions for the min/max tracker.
//   fp32_t           raw IEEE-754 single-precision bit pattern
//   field constants  bit positions of sign, exponent and mantissa
//   fminmax_state_e  scheduler states of fminmax_seq
//   fp_mag()         sign-stripped {exponent, mantissa} magnitude
package fp_pkg;

  typedef logic [31:0] fp32_t;

  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned MANT_MSB = 22;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_CMP_MIN,
    ST_CMP_MAX,
    ST_DONE
  } fminmax_state_e;

  function automatic logic [30:0] fp_mag(input fp32_t v);
    return {v[EXP_MSB:EXP_LSB], v[MANT_MSB:0]};
  endfunction

endpackage

// File: rtl/fp32_lt.sv
// Combinational fp32 less-than on raw bit patterns.
//   a, b : operands
//   lt   : 1 when a orders strictly below b
// Sign decides first (-0 < +0); equal signs compare magnitudes, reversed
// for negatives. NaN/Inf get no special treatment; equal patterns give 0.
module fp32_lt
  import fp_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  output logic  lt
);

  always_comb begin
    lt = 1'b0;
    if (a != b) begin
      if (a[SIGN_BIT] != b[SIGN_BIT]) begin
        lt = a[SIGN_BIT];
      end else if (!a[SIGN_BIT]) begin
        lt = (fp_mag(a) < fp_mag(b));
      end else begin
        lt = (fp_mag(a) > fp_mag(b));
      end
    end
  end

endmodule

// File: rtl/fminmax_seq.sv
// Streaming fp32 running min/max tracker sharing one comparator.
//   clk, rst_n           clock, async active-low reset
//   start                opens a burst (honoured in IDLE only)
//   in_valid/in_ready    sample handshake, in_data sample, in_last end of burst
//   res_valid/res_ready  result handshake
//   res_min/res_max      running extrema, res_count samples accepted (saturating)
//   busy                 FSM not in IDLE
// Each non-first sample costs three cycles: accept, min check, max check.
module fminmax_seq
  import fp_pkg::*;
#(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic               in_last,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [31:0]        res_min,
  output logic [31:0]        res_max,
  output logic [COUNT_W-1:0] res_count,
  output logic               busy
);

  fminmax_state_e     state_q, state_d;
  logic               first_q, first_d;
  fp32_t              s_q, s_d;
  logic               l_q, l_d;
  fp32_t              min_q, min_d;
  fp32_t              max_q, max_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  fp32_t cmp_a, cmp_b;
  logic  cmp_lt;

  fp32_lt u_lt (
    .a  (cmp_a),
    .b  (cmp_b),
    .lt (cmp_lt)
  );

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    s_d     = s_q;
    l_d     = l_q;
    min_d   = min_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    cmp_a   = s_q;
    cmp_b   = min_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          min_d   = '0;
          max_d   = '0;
          cnt_d   = '0;
          first_d = 1'b1;
          state_d = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (in_valid) begin
          s_d = in_data;
          l_d = in_last;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (first_q) begin
            // First sample seeds both accumulators; no compare needed.
            min_d   = in_data;
            max_d   = in_data;
            first_d = 1'b0;
            state_d = in_last ? ST_DONE : ST_ACCEPT;
          end else begin
            state_d = ST_CMP_MIN;
          end
        end
      end
      ST_CMP_MIN: begin
        cmp_a = s_q;
        cmp_b = min_q;
        if (cmp_lt) begin
          min_d = s_q;
        end
        state_d = ST_CMP_MAX;
      end
      ST_CMP_MAX: begin
        cmp_a = max_q;
        cmp_b = s_q;
        if (cmp_lt) begin
          max_d = s_q;
        end
        state_d = l_q ? ST_DONE : ST_ACCEPT;
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      first_q <= 1'b0;
      s_q     <= '0;
      l_q     <= 1'b0;
      min_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      s_q     <= s_d;
      l_q     <= l_d;
      min_q   <= min_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_ACCEPT);
  assign res_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign res_min   = min_q;
  assign res_max   = max_q;
  assign res_count = cnt_q;

endmodule
